arm_step_ctrl: RTL

- Execution controller between the board switches and the ARM_64 core.
- Debounces the switch commands and sequences the core through three modes: halted, single step and free run. The core advances only on a one-cycle clock-enable pulse, `cpu_en`.
- Counts executed core cycles and drives the board LEDs from either the core's LED output or the cycle counter.

---
 rtl/arm_ctrl_pkg.sv | 10 +
 rtl/arm_step_ctrl_sw_debounce.sv | 31 +++
 rtl/arm_step_ctrl.sv | 66 ++++++
 3 files changed

// File: rtl/arm_ctrl_pkg.sv
// arm_ctrl_pkg: shared mode encoding and switch bit indices
package arm_ctrl_pkg;
  typedef enum logic [1:0] {HALTED = 2'd0, STEP = 2'd1, RUN = 2'd2} mode_t;
  localparam int IDX_HALT = 0;
  localparam int IDX_STEP = 1;
  localparam int IDX_RUN = 2;
  localparam int IDX_LEDSEL = 3;
  localparam int IDX_CLR = 4;
  localparam int N_SW = 5;
endpackage

// File: rtl/arm_step_ctrl_sw_debounce.sv
// sw_debounce: two-flop synchroniser, stability counter, debounced level and rising-edge pulse
module sw_debounce #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic deb,
  output logic rise
);
  localparam int CW = $clog2(DEB_CYCLES);
  logic s1, s2;
  logic [CW-1:0] cnt;
  logic hit;
  assign hit = (s2 != deb) && (cnt == CW'(DEB_CYCLES - 1));
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      cnt <= '0;
      deb <= 1'b0;
      rise <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      cnt <= (s2 == deb || hit) ? '0 : cnt + 1'b1;
      deb <= hit ? s2 : deb;
      rise <= hit & s2;
    end
  end
endmodule

// File: rtl/arm_step_ctrl.sv
// arm_step_ctrl: debounced halt/step/run sequencer for the core clock enable with cycle counter and LED mux
module arm_step_ctrl
  import arm_ctrl_pkg::*;
#(
  parameter int SW_W = 8,
  parameter int DEB_CYCLES = 4,
  parameter int RUN_DIV = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SW_W-1:0]  SW,
  input  logic [7:0]       cpu_leds,
  output logic             cpu_en,
  output logic [7:0]       LEDS,
  output logic [1:0]       mode,
  output logic [CNT_W-1:0] cycle_cnt
);
  localparam int DIV_W = RUN_DIV > 1 ? $clog2(RUN_DIV) : 1;
  mode_t state, state_n;
  logic [DIV_W-1:0] div, div_n;
  logic en_n, clr;
  logic [N_SW-1:0] deb, rise;
  logic unused_ok;
  for (genvar i = 0; i < N_SW; i++) begin : g_sw
    sw_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk(clk),
      .rst(rst),
      .raw(SW[i]),
      .deb(deb[i]),
      .rise(rise[i])
    );
  end
  assign unused_ok = ^{SW[SW_W-1:N_SW], deb[IDX_HALT], deb[IDX_STEP], deb[IDX_RUN], deb[IDX_CLR], rise[IDX_LEDSEL]};
  assign mode = state;
  always_comb begin
    state_n = state == STEP ? HALTED :
              state == RUN  ? (rise[IDX_HALT] ? HALTED : RUN) :
              rise[IDX_HALT] ? HALTED :
              rise[IDX_STEP] ? STEP :
              rise[IDX_RUN]  ? RUN : HALTED;
    clr = state == HALTED && rise[IDX_CLR] && !(rise[IDX_HALT] || rise[IDX_STEP] || rise[IDX_RUN]);
    div_n = (state == RUN && state_n == RUN && div != DIV_W'(RUN_DIV - 1)) ? div + 1'b1 : '0;
    en_n = state_n == STEP || (state_n == RUN && div_n == '0);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= HALTED;
      div <= '0;
      cpu_en <= 1'b0;
    end else begin
      state <= state_n;
      div <= div_n;
      cpu_en <= en_n;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt <= '0;
      LEDS <= '0;
    end else begin
      cycle_cnt <= clr ? '0 : (cpu_en && cycle_cnt != '1) ? cycle_cnt + 1'b1 : cycle_cnt;
      LEDS <= deb[IDX_LEDSEL] ? cycle_cnt[7:0] : cpu_en ? cpu_leds : LEDS;
    end
  end
endmodule
